mcpu_core_param: RTL

//  Parametrised successor of the 8-bit-opcode MCPU MOV core: same encoding (imm bit7, cond bit6, dst[5:3], src[2:0]),

---
 rtl/mcpu_core_param.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mcpu_core_param.sv
// MCPU MOV core with configurable data/address width, ROM-ready fetch stall and req/ack RAM handshake.
// Optional halt on unconditional 8'h00 is enabled by defining MCPU_HALT_EN.
module mcpu_core_param #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   input  logic              rom_valid,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              ram_req,
   output logic              ram_we,
   input  logic              ram_ack,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [DATA_W-1:0] alu_op,
   input  logic [DATA_W-1:0] alu_d,
   input  logic              alu_f,
   output logic [DATA_W-1:0] i,
   output logic [DATA_W-1:0] j,
   output logic [DATA_W-1:0] k,
   output logic              halted
);

   typedef enum logic [1:0] {RUN, RD_WAIT, WR_WAIT, HALT} state_t;

   // Operand field encodings: codes 3 and 4 differ between source and destination
   localparam logic [2:0] R_PC   = 3'd0;
   localparam logic [2:0] R_ADDR = 3'd1;
   localparam logic [2:0] R_RAM  = 3'd2;
   localparam logic [2:0] R_IMM  = 3'd3;
   localparam logic [2:0] R_ALUA = 3'd3;
   localparam logic [2:0] R_ALU  = 3'd4;
   localparam logic [2:0] R_ALUB = 3'd4;
   localparam logic [2:0] R_I    = 3'd5;
   localparam logic [2:0] R_J    = 3'd6;
   localparam logic [2:0] R_K    = 3'd7;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [DATA_W-1:0] i_q, i_d;
   logic [DATA_W-1:0] j_q, j_d;
   logic [DATA_W-1:0] k_q, k_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [2:0]        dst_q, dst_d;
   logic              last_imm_q, last_imm_d;

   logic [DATA_W-1:0] pc_inc;
   logic [DATA_W-1:0] bus;
   logic [2:0]        op_dst, op_src;
   logic              op_exec, halt_op;
   logic              wr_en;
   logic [2:0]        wr_dst;
   logic [DATA_W-1:0] wr_val;

   assign op_dst  = rom_data[5:3];
   assign op_src  = rom_data[2:0];
   assign op_exec = !rom_data[6] || alu_f;
   assign pc_inc  = pc_q + DATA_W'(1);

`ifdef MCPU_HALT_EN
   assign halt_op = (rom_data == 8'h00);
   assign halted  = (state_q == HALT);
`else
   assign halt_op = 1'b0;
   assign halted  = 1'b0;
`endif

   always_comb begin
      bus = '0;
      case (op_src)
         R_PC:    bus = pc_q;
         R_ADDR:  bus = addr_q;
         R_IMM:   bus = imm_q;
         R_ALU:   bus = alu_d;
         R_I:     bus = i_q;
         R_J:     bus = j_q;
         R_K:     bus = k_q;
         default: bus = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      imm_d      = imm_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      i_d        = i_q;
      j_d        = j_q;
      k_d        = k_q;
      wdata_d    = wdata_q;
      dst_d      = dst_q;
      last_imm_d = last_imm_q;
      wr_en      = 1'b0;
      wr_dst     = dst_q;
      wr_val     = ram_rdata;

      case (state_q)
         RUN: begin
            if (rom_valid) begin
               if (rom_data[7]) begin
                  imm_d      = last_imm_q ? {imm_q[DATA_W-8:0], rom_data[6:0]}
                                          : DATA_W'(rom_data[6:0]);
                  last_imm_d = 1'b1;
                  pc_d       = pc_inc;
               end else begin
                  last_imm_d = 1'b0;
                  if (halt_op) begin
                     state_d = HALT;
                  end else if (!op_exec) begin
                     pc_d = pc_inc;
                  end else if (op_src == R_RAM) begin
                     dst_d   = op_dst;
                     state_d = RD_WAIT;
                  end else if (op_dst == R_RAM) begin
                     wdata_d = bus;
                     state_d = WR_WAIT;
                  end else begin
                     wr_en  = 1'b1;
                     wr_dst = op_dst;
                     wr_val = bus;
                  end
               end
            end
         end
         RD_WAIT: begin
            if (ram_ack) begin
               // RAM-to-RAM copy chains straight into the write phase
               if (dst_q == R_RAM) begin
                  wdata_d = ram_rdata;
                  state_d = WR_WAIT;
               end else begin
                  wr_en   = 1'b1;
                  state_d = RUN;
               end
            end
         end
         WR_WAIT: begin
            if (ram_ack) begin
               pc_d    = pc_inc;
               state_d = RUN;
            end
         end
         HALT: state_d = HALT;
         default: state_d = RUN;
      endcase

      if (wr_en) begin
         pc_d = pc_inc;
         case (wr_dst)
            R_PC:    pc_d    = wr_val;
            R_ADDR:  addr_d  = wr_val;
            R_ALUA:  alu_a_d = wr_val;
            R_ALUB:  alu_b_d = wr_val;
            R_I:     i_d     = wr_val;
            R_J:     j_d     = wr_val;
            R_K:     k_d     = wr_val;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= RUN;
         pc_q       <= '0;
         addr_q     <= '0;
         imm_q      <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         i_q        <= '0;
         j_q        <= '0;
         k_q        <= '0;
         wdata_q    <= '0;
         dst_q      <= '0;
         last_imm_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         imm_q      <= imm_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         i_q        <= i_d;
         j_q        <= j_d;
         k_q        <= k_d;
         wdata_q    <= wdata_d;
         dst_q      <= dst_d;
         last_imm_q <= last_imm_d;
      end
   end

   assign rom_addr  = pc_q[ADDR_W-1:0];
   assign ram_addr  = addr_q[ADDR_W-1:0];
   assign ram_wdata = wdata_q;
   assign ram_req   = (state_q == RD_WAIT) || (state_q == WR_WAIT);
   assign ram_we    = (state_q == WR_WAIT);
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = imm_q;
   assign i         = i_q;
   assign j         = j_q;
   assign k         = k_q;

endmodule
